// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// A WIDTH-bit word is accepted on a valid/ready handshake and shifted out
// one bit per clock, framed by sout_valid / sout_first / sout_last. A
// one-word holding buffer lets the next word wait while the current frame
// is in flight, so back-to-back frames stream with no idle cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   din        parallel word to transmit
//   din_valid  din holds a word
//   din_ready  a word can be accepted this cycle
//   sout       serial data bit (registered)
//   sout_valid sout carries a frame bit
//   sout_first sout is bit 0 of a frame
//   sout_last  sout is the final bit of a frame
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            buf_full;
  logic [WIDTH-1:0] shreg_p0;
  logic [WIDTH-1:0] buf_p0;

  logic             xfer;
  logic             at_last;
  logic             load;
  logic [WIDTH-1:0] load_w;
  logic [WIDTH-1:0] shreg_adv;
  logic [CW-1:0]    cnt_nxt;

  // Drop the bit just sent so the next one sits at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return w >> 1;
    else           return w << 1;
  endfunction

  function automatic logic head(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return w[0];
    else           return w[WIDTH-1];
  endfunction

  assign din_ready = (state == IDLE) || !buf_full;
  assign xfer      = din_valid && din_ready;
  assign at_last   = (cnt == LAST);
  assign shreg_adv = advance(shreg_p0);
  assign cnt_nxt   = cnt + 1'b1;

  // A new frame starts either from IDLE on a transfer, or at the last bit of
  // the current frame: the buffered word wins, otherwise din bypasses the
  // buffer (only possible when the buffer is empty, since din_ready is 0
  // while it is full).
  always_comb begin
    load   = 1'b0;
    load_w = din;
    if (state == IDLE) begin
      load = xfer;
    end else if (at_last) begin
      if (buf_full) begin
        load   = 1'b1;
        load_w = buf_p0;
      end else begin
        load = xfer;
      end
    end
  end

  // Stage p0: control and framing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      buf_full   <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
    end else begin
      if (load) begin
        state      <= SHIFT;
        cnt        <= '0;
        sout       <= head(load_w);
        sout_valid <= 1'b1;
        sout_first <= 1'b1;
        sout_last  <= (WIDTH == 1);
        if (state == SHIFT && buf_full) buf_full <= 1'b0;
      end else if (state == SHIFT && !at_last) begin
        cnt        <= cnt_nxt;
        sout       <= head(shreg_adv);
        sout_first <= 1'b0;
        sout_last  <= (cnt_nxt == LAST);
        if (xfer) buf_full <= 1'b1;
      end else begin
        state      <= IDLE;
        cnt        <= '0;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        sout_first <= 1'b0;
        sout_last  <= 1'b0;
      end
    end
  end

  // Stage p0: data registers, qualified by the control state above.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg_p0 <= load_w;
    end else if (state == SHIFT) begin
      shreg_p0 <= shreg_adv;
    end
    if (state == SHIFT && !at_last && xfer) begin
      buf_p0 <= din;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] din0 = '0, din1 = '0;
  logic [0:0] din2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       rdy0, rdy1, rdy2;
  logic       so0, sv0, sf0, sl0;
  logic       so1, sv1, sf1, sl1;
  logic       so2, sv2, sf2, sl2;

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .sout(so0), .sout_valid(sv0), .sout_first(sf0), .sout_last(sl0));

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .sout(so1), .sout_valid(sv1), .sout_first(sf1), .sout_last(sl1));

  piso_tx #(.WIDTH(1), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .sout(so2), .sout_valid(sv2), .sout_first(sf2), .sout_last(sl2));

  typedef struct {
    logic b;
    logic f;
    logic l;
    int   c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: bit i of 'bits' (MSB = first sent), with frame
  // strobes derived from the frame length and the cycle it must appear in.
  task automatic exp_seq(input int id, input logic [15:0] bits, input int n,
                         input int fw, input int t);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = bits[n-1-i];
      e.f = ((i % fw) == 0);
      e.l = ((i % fw) == fw - 1);
      e.c = t + i;
      case (id)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int id, input logic v, input logic s,
                     input logic f, input logic l);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!v) begin
      chk($sformatf("idle_out%0d", id), {29'd0, s, f, l}, 32'd0);
    end else begin
      case (id)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_bit%0d: got sout=%0b first=%0b last=%0b, required no frame bit (cycle %0d)",
                 id, s, f, l, cyc);
      end else begin
        chk($sformatf("bit%0d", id), {29'd0, s, f, l}, {29'd0, e.b, e.f, e.l});
        chk($sformatf("bit_cycle%0d", id), cyc, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, sv0, so0, sf0, sl0);
      mon(1, sv1, so1, sf1, sl1);
      mon(2, sv2, so2, sf2, sl2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) tick();
  endtask

  int t;

  initial begin
    // Reset
    tick();
    mon_en = 1'b1;
    chk("rst_rdy0", rdy0, 1);
    chk("rst_rdy1", rdy1, 1);
    chk("rst_rdy2", rdy2, 1);
    tick();
    rst = 1'b0;

    // Idle for 10 cycles
    repeat (10) begin
      tick();
      chk("idle_rdy0", rdy0, 1);
      chk("idle_rdy1", rdy1, 1);
      chk("idle_rdy2", rdy2, 1);
    end

    // Single word 1011, MSB first
    t = cyc + 1;
    exp_seq(0, 16'b1011, 4, 4, t);
    din0 = 4'b1011; v0 = 1'b1;
    tick();
    v0 = 1'b0; din0 = 4'h0;
    wait_cyc(t + 4);
    chk("single_idle_rdy", rdy0, 1);
    tick();

    // Back-to-back A then 5, second word waits in the buffer
    t = cyc + 1;
    exp_seq(0, 16'b1010_0101, 8, 4, t);
    din0 = 4'hA; v0 = 1'b1;
    tick();
    din0 = 4'h5;
    tick();
    v0 = 1'b0; din0 = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(t + k);
      chk("b2b_rdy_full", rdy0, 0);
    end
    wait_cyc(t + 4);
    chk("b2b_rdy_free", rdy0, 1);
    wait_cyc(t + 9);

    // Bypass: C, then 3 presented exactly in the last-bit cycle
    t = cyc + 1;
    exp_seq(0, 16'b1100_0011, 8, 4, t);
    din0 = 4'hC; v0 = 1'b1;
    tick();
    v0 = 1'b0; din0 = 4'h0;
    wait_cyc(t + 3);
    chk("bypass_rdy_last", rdy0, 1);
    din0 = 4'h3; v0 = 1'b1;
    tick();
    v0 = 1'b0; din0 = 4'h0;
    chk("bypass_rdy_after", rdy0, 1);
    wait_cyc(t + 9);

    // LSB first: 0001 then 0110 back-to-back
    t = cyc + 1;
    exp_seq(1, 16'b1000_0110, 8, 4, t);
    din1 = 4'b0001; v1 = 1'b1;
    tick();
    din1 = 4'b0110;
    tick();
    v1 = 1'b0; din1 = 4'h0;
    wait_cyc(t + 9);

    // WIDTH=1: valid held for three words, continuous bypass
    t = cyc + 1;
    exp_seq(2, 16'b101, 3, 1, t);
    din2 = 1'b1; v2 = 1'b1;
    tick();
    chk("w1_rdy_a", rdy2, 1);
    din2 = 1'b0;
    tick();
    chk("w1_rdy_b", rdy2, 1);
    din2 = 1'b1;
    tick();
    v2 = 1'b0; din2 = 1'b0;
    wait_cyc(t + 5);

    // Reset mid-frame: F in flight, 9 buffered, reset in the frame's 2nd cycle
    t = cyc + 1;
    exp_seq(0, 16'b11, 2, 4, t);
    din0 = 4'hF; v0 = 1'b1;
    tick();
    din0 = 4'h9;
    tick();
    v0 = 1'b0; din0 = 4'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_rdy", rdy0, 1);
    wait_cyc(t + 12);
    chk("rst_mid_rdy_late", rdy0, 1);

    // Drain, bounded
    for (int k = 0; k < 20; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      tick();
    end
    if (q0.size() + q1.size() + q2.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected bits never appeared, required 0",
               q0.size() + q1.size() + q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter: the transmit end paired with the team's 4-stage serial shift chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Marks each frame with valid, first-bit and last-bit strobes.
- A one-word holding buffer allows back-to-back frames with no idle gap between them.

Parameters:
WIDTH, 4, word length in bits and serial frame length in cycles; legal range is 1 to 32.
LSB_FIRST, 0, 0 sends din[WIDTH-1] first (MSB first); 1 sends din[0] first.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
din  input  WIDTH  parallel word to transmit.
din_valid  input  1  din holds a word to send.
din_ready  output  1  block can accept a word this cycle; a transfer happens when din_valid and din_ready are both 1 at a rising edge.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit this cycle.
sout_first  output  1  sout is bit 0 of a frame.
sout_last  output  1  sout is the final bit of a frame.

Behaviour:
- Only one clock exists. Reset is synchronous and active-high: rst is sampled at the rising edge of clk.
- Reset values: sout=0, sout_valid=0, sout_first=0, sout_last=0, din_ready=1, state=IDLE, holding buffer empty, bit counter=0.
- Reset mid-frame aborts the frame at the next edge. The shifter and buffer contents are discarded, no partial bits follow, and all outputs take their reset values.
- States: IDLE and SHIFT.
- IDLE:
  - din_ready=1 and all sout_* outputs are 0.
  - On a transfer, din loads the shift register, counter=0, next state SHIFT.
  - Latency: bit 0 appears on sout in the cycle after the transfer edge.
- SHIFT:
  - Each cycle drives one bit from the shift register. sout_valid=1, sout_first=(counter==0), sout_last=(counter==WIDTH-1).
  - Counter increments each cycle.
- din_ready during SHIFT equals "buffer empty".
  - A transfer in SHIFT writes the buffer, except in the last-bit cycle as described below.
- Last-bit cycle (counter==WIDTH-1):
  - Buffer full: buffer moves to the shift register, buffer empties, counter=0, stay in SHIFT. The next frame's bit 0 follows in the next cycle with no gap.
  - Buffer empty with a transfer in the same cycle: din bypasses the buffer straight into the shift register, stay in SHIFT, no gap.
  - Buffer empty with no transfer: next state IDLE; sout_* return to 0 next cycle.
- Bit order:
  - LSB_FIRST=0: register shifts left and sout=reg[WIDTH-1].
  - LSB_FIRST=1: register shifts right and sout=reg[0].
  - Output bits are registered; no combinational path from din to sout.
- WIDTH=1: every SHIFT cycle asserts both sout_first and sout_last.
- din_valid without din_ready is ignored. The block never samples din except at a transfer edge.
- Counter width is clog2(WIDTH), minimum 1; counter never exceeds WIDTH-1.
- Throughput: with din_valid held high, the output is a continuous stream of 1 bit per cycle.

Test Plan:
- Single word, WIDTH=4, LSB_FIRST=0, din=4'b1011 accepted at edge 0 -> sout=1,0,1,1 at cycles 1-4. sout_valid=1 in cycles 1-4, sout_first only at cycle 1, sout_last only at cycle 4. State is IDLE at cycle 5 with all sout_*=0.
- Back-to-back: din=4'hA at edge 0, then 4'h5 with din_valid held -> 4'h5 is buffered at edge 1 and din_ready=0 for cycles 2-4. Output is 1,0,1,0,0,1,0,1 contiguous over cycles 1-8, with sout_first at cycles 1 and 5 and sout_last at cycles 4 and 8.
- Bypass: accept 4'hC, drop din_valid, then present 4'h3 exactly in the last-bit cycle -> 1,1,0,0,0,0,1,1 with no gap, buffer never used.
- LSB_FIRST=1, din=4'b0001 -> sout=1,0,0,0.
- Reset mid-frame: rst=1 at cycle 2 of frame 4'hF with buffer holding 4'h9 -> from cycle 3 sout=0, sout_valid=0, din_ready=1. 4'h9 is never transmitted.
- Idle behaviour: din_valid=0 for 10 cycles after reset -> sout=0, sout_valid=0, din_ready=1 throughout.
